// File: rtl/alu_pkg.sv
// Shared ALU/M-extension definitions: opcodes, sequencer state encoding, operand width
// and opcode classification helpers used by the EX-stage units.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } muldiv_state_e;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // MUL keeps unsigned magnitudes: its low product half is sign-agnostic.
    function automatic logic rs1_signed(input logic [4:0] op);
        logic s;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic rs2_signed(input logic [4:0] op);
        logic s;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request/response bundle between the pipeline control and the M-extension sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = alu_pkg::XLEN_DEF);

    logic            start;
    logic [4:0]      opcode;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            ready;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, opcode, data1, data2, flush,
        input  ready, stall, result_valid, result
    );

    modport slave (
        input  start, opcode, data1, data2, flush,
        output ready, stall, result_valid, result
    );

endinterface

// File: rtl/muldiv_iter_datapath.sv
// One radix-2 step: shift-add multiply ({hi,lo} shifted right) or restoring divide
// ({remainder,quotient} shifted left) on unsigned magnitudes.
module muldiv_iter_datapath #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_hi_s;
    logic [XLEN-1:0] div_diff_s;
    logic            div_ge_s;

    // Single iteration of either algorithm, selected by is_div.
    always_comb begin
        mul_sum_s  = {1'b0, acc[2*XLEN-1:XLEN]};
        if (acc[0]) begin
            mul_sum_s = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        end else begin
            mul_sum_s = {1'b0, acc[2*XLEN-1:XLEN]};
        end
        // Shifted partial remainder can reach 2*divisor-1, hence the extra top bit.
        div_hi_s   = acc[2*XLEN-1:XLEN-1];
        div_ge_s   = (div_hi_s >= {1'b0, operand});
        div_diff_s = div_hi_s[XLEN-1:0] - operand;
        if (is_div) begin
            if (div_ge_s) begin
                acc_next = {div_diff_s, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {div_hi_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum_s, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: IDLE/BUSY/DONE control, operand sign handling, fast paths.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier (IDLE->DONE).
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_r, next_state_s;
    logic [5:0]        cnt_r;
    logic [2*XLEN-1:0] acc_r, acc_next_s, init_acc_s, prod_s;
    logic [XLEN-1:0]   operand_r, init_operand_s;
    logic [XLEN-1:0]   mag1_s, mag2_s, quo_s, rem_s;
    logic [XLEN-1:0]   result_r, fast_result_s, final_result_s, fast_mul_result_s;
    logic [4:0]        op_r;
    logic              sign1_r, sign2_r, sign1_s, sign2_s;
    logic              accept_s, fast_s, fast_mul_s, last_iter_s;

    muldiv_iter_datapath #(.XLEN(XLEN)) u_datapath (
        .is_div   (is_div_op(op_r)),
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (acc_next_s)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a_s, fm_b_s, fm_prod_s;

    // Sign/zero-extend both operands so one 2*XLEN product serves all four multiplies.
    always_comb begin
        fm_a_s     = {{XLEN{rs1_signed(bus.opcode) & bus.data1[XLEN-1]}}, bus.data1};
        fm_b_s     = {{XLEN{rs2_signed(bus.opcode) & bus.data2[XLEN-1]}}, bus.data2};
        fm_prod_s  = fm_a_s * fm_b_s;
        fast_mul_s = ~is_div_op(bus.opcode);
        if (bus.opcode == OP_MUL) begin
            fast_mul_result_s = fm_prod_s[XLEN-1:0];
        end else begin
            fast_mul_result_s = fm_prod_s[2*XLEN-1:XLEN];
        end
    end
`else
    assign fast_mul_s        = 1'b0;
    assign fast_mul_result_s = {XLEN{1'b0}};
`endif

    // Operand magnitudes and datapath seed for the request on the bus.
    always_comb begin
        sign1_s = rs1_signed(bus.opcode) & bus.data1[XLEN-1];
        sign2_s = rs2_signed(bus.opcode) & bus.data2[XLEN-1];
        if (sign1_s) begin
            mag1_s = -bus.data1;
        end else begin
            mag1_s = bus.data1;
        end
        if (sign2_s) begin
            mag2_s = -bus.data2;
        end else begin
            mag2_s = bus.data2;
        end
        if (is_div_op(bus.opcode)) begin
            init_acc_s     = {{XLEN{1'b0}}, mag1_s};
            init_operand_s = mag2_s;
        end else begin
            init_acc_s     = {{XLEN{1'b0}}, mag2_s};
            init_operand_s = mag1_s;
        end
    end

    // Requests that complete without iterating: divide by zero, signed overflow, fast multiply.
    always_comb begin
        fast_s        = 1'b0;
        fast_result_s = {XLEN{1'b0}};
        if (is_div_op(bus.opcode) && (bus.data2 == {XLEN{1'b0}})) begin
            fast_s = 1'b1;
            case (bus.opcode)
                OP_DIV, OP_DIVU: fast_result_s = {XLEN{1'b1}};
                default:         fast_result_s = bus.data1;
            endcase
        end else if (((bus.opcode == OP_DIV) || (bus.opcode == OP_REM)) &&
                     (bus.data1 == INT_MIN) && (bus.data2 == {XLEN{1'b1}})) begin
            fast_s = 1'b1;
            if (bus.opcode == OP_DIV) begin
                fast_result_s = INT_MIN;
            end else begin
                fast_result_s = {XLEN{1'b0}};
            end
        end else if (fast_mul_s) begin
            fast_s        = 1'b1;
            fast_result_s = fast_mul_result_s;
        end else begin
            fast_s        = 1'b0;
            fast_result_s = {XLEN{1'b0}};
        end
    end

    // Sign fix-up of the final iteration's accumulator.
    always_comb begin
        quo_s = acc_next_s[XLEN-1:0];
        rem_s = acc_next_s[2*XLEN-1:XLEN];
        if (sign1_r ^ sign2_r) begin
            prod_s = -acc_next_s;
        end else begin
            prod_s = acc_next_s;
        end
        case (op_r)
            OP_MUL:                        final_result_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_result_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_result_s = (sign1_r ^ sign2_r) ? -quo_s : quo_s;
            OP_REM, OP_REMU:               final_result_s = sign1_r ? -rem_s : rem_s;
            default:                       final_result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state decode; FLUSH beats START in IDLE and aborts BUSY/DONE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_iter_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!bus.flush && bus.start && is_m_op(bus.opcode)) begin
                    accept_s = 1'b1;
                    if (fast_s) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_BUSY;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    next_state_s = S_IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    last_iter_s  = 1'b1;
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_BUSY;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latch, iteration state and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r     <= {(2*XLEN){1'b0}};
            operand_r <= {XLEN{1'b0}};
            cnt_r     <= 6'd0;
            op_r      <= 5'd0;
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else if (accept_s) begin
            acc_r     <= init_acc_s;
            operand_r <= init_operand_s;
            cnt_r     <= 6'd0;
            op_r      <= bus.opcode;
            sign1_r   <= sign1_s;
            sign2_r   <= sign2_s;
            if (fast_s) begin
                result_r <= fast_result_s;
            end else begin
                result_r <= result_r;
            end
        end else if ((state_r == S_BUSY) && !bus.flush) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 6'd1;
            if (last_iter_s) begin
                result_r <= final_result_s;
            end else begin
                result_r <= result_r;
            end
        end else begin
            result_r <= result_r;
        end
    end

    assign bus.ready        = (state_r == S_IDLE);
    assign bus.stall        = (state_r == S_BUSY) | accept_s;
    assign bus.result_valid = (state_r == S_DONE) & ~bus.flush;
    assign bus.result       = result_r;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage, beside the single-cycle alu.
- Accepts one operation per START/READY handshake and runs a radix-2 iterative shift-add / restoring-divide datapath.
- Holds STALL high to freeze IF/ID/EX while busy, then returns the result with a one-cycle RESULT_VALID pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only when READY=1.
- OPCODE  input  5  ALU opcode; only M codes (package constants, 5'd10..5'd17) are valid.
- DATA1  input  XLEN  rs1 operand.
- DATA2  input  XLEN  rs2 operand.
- FLUSH  input  1  pipeline flush; aborts the operation in flight.
- READY  output  1  high in IDLE only.
- STALL  output  1  high from the accept cycle until RESULT_VALID is asserted, inclusive of BUSY.
- RESULT_VALID  output  1  one-cycle pulse in DONE.
- RESULT  output  XLEN  result; stable from DONE until the next accept.

Behaviour:
- Reset (RESET=1 at an edge, any state):
  - state=IDLE; READY=1; STALL=0; RESULT_VALID=0; RESULT=0.
  - Internal accumulator, counter and sign flags cleared.
  - Mid-operation reset discards the operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - START=1 with a valid M opcode latches opcode, operand signs and magnitudes.
  - STALL is asserted combinationally from START&valid in the same cycle.
  - Next state is BUSY, or DONE for the fast paths below.
  - START with a non-M opcode is ignored: stay IDLE, no pulse.
- BUSY:
  - One iteration per cycle; 6-bit counter runs 0..XLEN-1, and the last iteration moves to DONE.
  - Accept at edge t0 gives RESULT_VALID high in cycle t0+XLEN+1, i.e. 33 cycles after accept.
- DONE:
  - RESULT_VALID=1 for exactly one cycle, STALL=0, then IDLE.
  - START is not sampled in DONE. A back-to-back operation is accepted the following cycle.
- Multiply:
  - Operands are converted to magnitudes per signedness: MULH both signed, MULHSU rs1 signed, MULHU none.
  - 2*XLEN unsigned product, then conditional negate.
  - MUL returns bits [XLEN-1:0]; the H variants return [2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign1 XOR sign2 (signed ops only). Remainder sign = sign of dividend.
- Fast paths (DONE at t0+1, no BUSY):
  - DATA2=0: DIV/DIVU return all-ones; REM/REMU return DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- FLUSH:
  - In BUSY or DONE: return to IDLE next edge, no RESULT_VALID, RESULT unchanged.
  - In IDLE: a simultaneous START is not accepted; FLUSH has priority.
  - RESET has priority over FLUSH.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a single-cycle synthesized multiplier and go IDLE→DONE, with RESULT_VALID at t0+1. Divides are unchanged.
- Undefined: multiplies use the iterative path with XLEN+1 cycle latency. No multiplier is inferred.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams, including OP_MUL=10, OP_MULH=11, OP_MULHSU=12, OP_MULHU=13, OP_DIV=14, OP_DIVU=15, OP_REM=16, OP_REMU=17.
  - State encoding localparams.
  - XLEN default.
- One sub-module, muldiv_iter_datapath: per-cycle shift-add / restore-subtract step.
  - Inputs: mode, accumulator, operands.
  - Outputs: next accumulator.
  - The sequencer owns the FSM, counter, fast paths and sign fix-up.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: MUL 6*3, assert RESET at accept+10.
  - Required: next cycle READY=1, STALL=0, RESULT=0, no RESULT_VALID.
- MUL 6*3 (iterative build):
  - Stimulus: START at t0.
  - Required: STALL high t0..t0+32; RESULT_VALID only at t0+33 with RESULT=18; READY back at t0+34.
- MULH:
  - 0xFFFFFFFA (-6) * 3 → 0xFFFFFFFF.
  - MULHU with the same operands → 0x00000002.
  - MUL with the same operands → 0xFFFFFFEE.
- DIV/REM:
  - DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1).
  - DIVU 7/2 → 3; REMU 7/2 → 1.
- Fast paths, each with RESULT_VALID at t0+1:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- FLUSH and invalid opcode:
  - FLUSH at accept+5 → IDLE next cycle, no pulse, RESULT unchanged.
  - START with OPCODE=5'd3 → READY stays 1, STALL=0.
  - With MULDIV_FAST_MUL_EN defined, MUL 6*3 → RESULT_VALID at t0+1 with RESULT=18.
